// File: rtl/note_judge.sv
// Rhythm-game judgement stage: judges chart notes against synchronized lane presses
// and publishes per-frame score/combo/precise totals that hold for the following frame.
module note_judge #(
  parameter logic [15:0] PERFECT_WIN = 16'd40,
  parameter logic [15:0] GOOD_WIN    = 16'd80,
  parameter logic [15:0] BAD_WIN     = 16'd120,
  parameter logic [12:0] PERFECT_PTS = 13'd300,
  parameter logic [12:0] GOOD_PTS    = 13'd100,
  parameter logic [12:0] BAD_PTS     = 13'd50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        new_frame,
  input  logic [15:0] un_time,
  input  logic [3:0]  key_down,
  input  logic        note_valid,
  input  logic [1:0]  note_lane,
  input  logic [15:0] note_time,
  output logic        note_pop,
  output logic [12:0] score,
  output logic [3:0]  combo,
  output logic [1:0]  precise
);

  typedef enum logic [1:0] {IDLE, CHECK, POP, LATCH} state_t;
  typedef enum logic [2:0] {J_NONE, J_PERF, J_GOOD, J_BAD, J_MISS} judge_t;

  state_t state, state_n;
  judge_t jd;

  logic [3:0]  k_meta, k_sync, k_prev, pend, key_rise, clr;
  logic        nf_q, nf_rise, frame_pend;
  logic [12:0] acc_score, pts, score_sat;
  logic [13:0] score_sum;
  logic [3:0]  acc_combo;
  logic [1:0]  sev;

  logic signed [16:0] delta, bad_s;
  logic [16:0]        mag;
  logic               late, early;

  assign key_rise = k_sync & ~k_prev;
  assign nf_rise  = new_frame & ~nf_q;

  // 17-bit signed difference; song time never wraps, so no modular handling
  assign delta = {1'b0, un_time} - {1'b0, note_time};
  assign bad_s = {1'b0, BAD_WIN};
  assign mag   = delta[16] ? 17'(-delta) : 17'(delta);
  assign late  = delta > bad_s;
  assign early = delta < -bad_s;

  assign note_pop = (state == POP) && active;

  always_comb begin
    state_n = state;
    jd      = J_NONE;
    clr     = '0;
    case (state)
      IDLE: begin
        if (frame_pend)                state_n = LATCH;
        else if (active && note_valid) state_n = CHECK;
      end
      CHECK: begin
        state_n = IDLE;
        if (!active) begin
          state_n = IDLE;
        end else if (late) begin
          jd      = J_MISS;
          state_n = POP;
        end else if (pend[note_lane]) begin
          clr[note_lane] = 1'b1;
          if (!early) begin
            state_n = POP;
            if (mag <= {1'b0, PERFECT_WIN})   jd = J_PERF;
            else if (mag <= {1'b0, GOOD_WIN}) jd = J_GOOD;
            else                              jd = J_BAD;
          end
        end
      end
      POP:     state_n = IDLE;
      LATCH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pts = '0;
    case (jd)
      J_PERF:  pts = PERFECT_PTS;
      J_GOOD:  pts = GOOD_PTS;
      J_BAD:   pts = BAD_PTS;
      default: pts = '0;
    endcase
    score_sum = {1'b0, acc_score} + {1'b0, pts};
    score_sat = score_sum[13] ? 13'h1fff : score_sum[12:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k_meta     <= '0;
      k_sync     <= '0;
      k_prev     <= '0;
      nf_q       <= 1'b0;
      frame_pend <= 1'b0;
      pend       <= '0;
      acc_score  <= '0;
      acc_combo  <= '0;
      sev        <= '0;
      score      <= '0;
      combo      <= '0;
      precise    <= '0;
    end else begin
      state  <= state_n;
      k_meta <= key_down;
      k_sync <= k_meta;
      k_prev <= k_sync;
      nf_q   <= new_frame;

      // an edge arriving in the LATCH cycle itself is kept, never dropped
      if (nf_rise)              frame_pend <= 1'b1;
      else if (state == LATCH)  frame_pend <= 1'b0;

      // a press edge in the same cycle as its consumption survives for the next CHECK
      if (!active)             pend <= '0;
      else if (state == LATCH) pend <= key_rise;
      else                     pend <= (pend & ~clr) | key_rise;

      if (!active || state == LATCH) begin
        acc_score <= '0;
        acc_combo <= '0;
        sev       <= '0;
      end else begin
        case (jd)
          J_PERF, J_GOOD: begin
            acc_score <= score_sat;
            acc_combo <= (acc_combo == 4'hf) ? 4'hf : acc_combo + 4'd1;
            sev       <= (sev > 2'd1) ? sev : 2'd1;
          end
          J_BAD: begin
            acc_score <= score_sat;
            sev       <= (sev > 2'd2) ? sev : 2'd2;
          end
          J_MISS:  sev <= 2'd3;
          default: ;
        endcase
      end

      if (state == LATCH) begin
        score   <= acc_score;
        combo   <= acc_combo;
        precise <= sev;
      end
    end
  end

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: a small chart FIFO, a judgement model computing frame
// totals from note/press times, and a per-cycle comparison of the published outputs.
module tb_note_judge;
  logic        clk = 1'b0, reset = 1'b0, active = 1'b0, new_frame = 1'b0;
  logic [15:0] un_time = '0;
  logic [3:0]  key_down = '0;
  logic        note_valid, note_pop;
  logic [1:0]  note_lane, precise;
  logic [15:0] note_time;
  logic [12:0] score;
  logic [3:0]  combo;

  logic [1:0]  fl [32];
  logic [15:0] ft [32];
  logic [4:0]  wr = '0, rd = '0;

  int  acc_s = 0, acc_c = 0, acc_p = 0, exp_s = 0, exp_c = 0, exp_p = 0;
  int  lit_n = 0, lit_f = 0, cmp_n = 0, cmp_f = 0, pops = 0, pop_ut = -1;
  time quiet_until = 0;

  assign note_valid = (rd != wr);
  assign note_lane  = fl[rd];
  assign note_time  = ft[rd];

  note_judge dut (
    .clk(clk), .reset(reset), .active(active), .new_frame(new_frame),
    .un_time(un_time), .key_down(key_down), .note_valid(note_valid),
    .note_lane(note_lane), .note_time(note_time), .note_pop(note_pop),
    .score(score), .combo(combo), .precise(precise)
  );

  always #5 clk = ~clk;

  // per-cycle compare of published totals plus FIFO consumption bookkeeping
  always @(negedge clk) begin
    if ($time > quiet_until) begin
      cmp_n++;
      if (score !== 13'(exp_s) || combo !== 4'(exp_c) || precise !== 2'(exp_p)) begin
        cmp_f++;
        $display("FAIL totals t=%0t got %0d/%0d/%0d want %0d/%0d/%0d",
                 $time, score, combo, precise, exp_s, exp_c, exp_p);
      end
    end
    if (note_pop) begin
      cmp_n++;
      if (rd == wr) begin
        cmp_f++;
        $display("FAIL pop_empty t=%0t got pop want no pop", $time);
      end else begin
        rd = rd + 5'd1;
        pops++;
        pop_ut = int'(un_time);
      end
    end
  end

  function automatic int judge(int d, bit pressed);
    int a;
    if (d > 120) return 4;
    if (!pressed || d < -120) return 0;
    a = (d < 0) ? -d : d;
    if (a <= 40) return 1;
    if (a <= 80) return 2;
    return 3;
  endfunction

  task automatic apply(int j);
    case (j)
      1, 2: begin
        acc_s = (acc_s + ((j == 1) ? 300 : 100) > 8191) ? 8191 : acc_s + ((j == 1) ? 300 : 100);
        acc_c = (acc_c == 15) ? 15 : acc_c + 1;
        acc_p = (acc_p > 1) ? acc_p : 1;
      end
      3: begin
        acc_s = (acc_s + 50 > 8191) ? 8191 : acc_s + 50;
        acc_p = (acc_p > 2) ? acc_p : 2;
      end
      4: acc_p = 3;
      default: ;
    endcase
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lchk(string name, logic [31:0] act, logic [31:0] expv);
    lit_n++;
    if (act !== expv) begin
      lit_f++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic push(logic [1:0] lane, int t);
    fl[wr] = lane;
    ft[wr] = 16'(t);
    wr = wr + 5'd1;
  endtask

  task automatic tap(int lane);
    key_down = 4'(1 << lane);
    tick(6);
    key_down = '0;
    tick(8);
  endtask

  task automatic frame();
    new_frame = 1'b1;
    exp_s = acc_s; exp_c = acc_c; exp_p = acc_p;
    acc_s = 0; acc_c = 0; acc_p = 0;
    quiet_until = $time + 100;
    tick(3);
    new_frame = 1'b0;
    tick(8);
  endtask

  task automatic totals(string name, int s, int c, int p);
    lchk({name, "_score"}, 32'(score), 32'(s));
    lchk({name, "_combo"}, 32'(combo), 32'(c));
    lchk({name, "_precise"}, 32'(precise), 32'(p));
  endtask

  int bd [7] = '{-40, 40, 41, -80, 81, -120, 121};
  bit bp [7] = '{1, 1, 1, 1, 1, 1, 0};
  int bs [7] = '{300, 300, 100, 100, 50, 50, 0};
  int bc [7] = '{1, 1, 1, 1, 0, 0, 0};
  int bpr[7] = '{1, 1, 1, 1, 2, 2, 3};

  initial begin
    int p0;
    bit seen;
    for (int i = 0; i < 32; i++) begin fl[i] = '0; ft[i] = '0; end

    // reset and idle frames
    tick(3);
    totals("reset", 0, 0, 0);
    lchk("reset_pop", 32'(note_pop), 0);
    reset = 1'b1; active = 1'b1;
    tick(3);
    repeat (3) frame();
    totals("idle", 0, 0, 0);
    lchk("idle_pops", 32'(pops), 0);

    // perfect hit, +30 ms
    un_time = 16'd1030;
    push(2'd2, 1000);
    tap(2);
    apply(judge(30, 1'b1));
    frame();
    totals("perfect", 300, 1, 1);
    lchk("perfect_pops", 32'(pops), 1);

    // unpressed note swept past the bad window
    un_time = 16'd480;
    push(2'd0, 500);
    for (int u = 480; u <= 625; u++) begin un_time = 16'(u); tick(4); end
    apply(judge(121, 1'b0));
    frame();
    totals("miss", 0, 0, 3);
    lchk("miss_pops", 32'(pops), 2);
    lchk("miss_time", 32'(pop_ut), 621);

    // good then bad in one frame
    push(2'd1, 2000);
    push(2'd3, 2005);
    un_time = 16'd2060;
    tap(1);
    apply(judge(60, 1'b1));
    un_time = 16'd2110;
    tap(3);
    apply(judge(105, 1'b1));
    frame();
    totals("good_bad", 150, 1, 2);
    lchk("good_bad_pops", 32'(pops), 4);

    // far-early tap is discarded, later tap is perfect
    un_time = 16'd100;
    push(2'd0, 400);
    tap(0);
    lchk("early_tap_pops", 32'(pops), 4);
    un_time = 16'd395;
    tick(10);
    lchk("pend_cleared_pops", 32'(pops), 4);
    tap(0);
    apply(judge(-5, 1'b1));
    frame();
    totals("late_perfect", 300, 1, 1);
    lchk("late_perfect_pops", 32'(pops), 5);

    // window boundaries, one frame each
    for (int i = 0; i < 7; i++) begin
      p0 = pops;
      un_time = 16'(6000 + i * 1000 + bd[i]);
      push(2'(i % 4), 6000 + i * 1000);
      if (bp[i]) tap(i % 4);
      else tick(10);
      apply(judge(bd[i], bp[i]));
      frame();
      totals($sformatf("edge%0d", bd[i]), bs[i], bc[i], bpr[i]);
      lchk($sformatf("edge%0d_pops", bd[i]), 32'(pops), 32'(p0 + 1));
    end

    // inactive song: no judging, pend dropped, zeros published
    p0 = pops;
    active = 1'b0;
    un_time = 16'd14000;
    push(2'd0, 14000);
    tap(0);
    lchk("inactive_pops", 32'(pops), 32'(p0));
    frame();
    totals("inactive", 0, 0, 0);
    active = 1'b1;
    tick(10);
    lchk("reactivate_pops", 32'(pops), 32'(p0));
    tap(0);
    apply(judge(0, 1'b1));
    frame();
    totals("reactivate", 300, 1, 1);

    // frame edge lands in the CHECK cycle of a perfect hit
    p0 = pops;
    un_time = 16'd20000;
    tap(1);
    push(2'd1, 20000);
    apply(judge(0, 1'b1));
    tick(1);
    frame();
    totals("edge_in_check", 300, 1, 1);
    lchk("edge_in_check_pops", 32'(pops), 32'(p0 + 1));

    // reset asserted while note_pop is high
    p0 = pops;
    un_time = 16'd30000;
    push(2'd2, 30000);
    key_down = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      seen = note_pop;
    end
    lchk("pop_seen", 32'(seen), 1);
    reset = 1'b0;
    exp_s = 0; exp_c = 0; exp_p = 0; acc_s = 0; acc_c = 0; acc_p = 0;
    #1;
    lchk("reset_pop_drop", 32'(note_pop), 0);
    totals("reset_mid", 0, 0, 0);
    key_down = '0;
    tick(3);
    reset = 1'b1;
    tick(10);
    lchk("reset_pops", 32'(pops), 32'(p0));
    frame();
    totals("after_reset", 0, 0, 0);

    $display("%0d/%0d checks passed", (lit_n - lit_f) + (cmp_n - cmp_f), lit_n + cmp_n);
    $finish;
  end
endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Rhythm-game judgement stage, directly upstream of the score/combo/precise overlay drawer.
- Consumes a time-sorted note stream from the chart FIFO, the current song time and four lane keys.
- Judges each note as hit/bad/miss and accumulates per-frame deltas.
- On each frame boundary, publishes frame totals (score, combo, precise) that stay stable for the whole next frame, so the drawer can sample them at its new_frame edge.

Parameters:
- PERFECT_WIN, 16'd40, max |delta| in ms for a perfect hit
- GOOD_WIN, 16'd80, max |delta| in ms for a good hit
- BAD_WIN, 16'd120, max |delta| in ms for bad; a note later than this is a miss
- PERFECT_PTS, 13'd300, score for perfect
- GOOD_PTS, 13'd100, score for good
- BAD_PTS, 13'd50, score for bad

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- active  input  1  song running; low = no judging, no pops, accumulators held at 0
- new_frame  input  1  frame-start level from the VGA/frame logic (clk domain)
- un_time  input  16  current song time, ms, unsigned
- key_down  input  4  raw lane keys, level, asynchronous
- note_valid  input  1  chart FIFO head is valid
- note_lane  input  2  head note lane
- note_time  input  16  head note target time, ms
- note_pop  output  1  one-cycle pulse, consumes the FIFO head
- score  output  13  score delta for the last completed frame
- combo  output  4  hit count for the last completed frame
- precise  output  2  worst judgement of the last frame: 0 none, 1 hit, 2 bad, 3 miss

Behaviour:
- Reset (reset=0): all outputs 0; accumulators, pending presses, frame_pend and sync flops cleared; FSM to IDLE. Reset mid-operation aborts any judgement and emits no pop.
- key_down passes through a 2-FF synchronizer. A rising edge on lane i sets pend[i]. pend is cleared on consumption or in LATCH.
- new_frame rising edge (registered compare) sets frame_pend.
- Signed delta = {1'b0,un_time} - {1'b0,note_time} (17 bit). Song length is below 65535 ms; no wrap handling.
- FSM states: IDLE, CHECK, POP, LATCH.
- IDLE:
  - frame_pend → LATCH (priority).
  - Else active && note_valid → CHECK.
- CHECK evaluates the head note against L = note_lane:
  - delta > BAD_WIN → MISS; → POP.
  - pend[L] && delta < -BAD_WIN → clear pend[L] (empty tap, no judgement); → IDLE.
  - pend[L] && |delta| <= PERFECT_WIN → PERFECT; clear pend[L]; → POP.
  - pend[L] && |delta| <= GOOD_WIN → GOOD; clear pend[L]; → POP.
  - pend[L] && |delta| <= BAD_WIN → BAD; clear pend[L]; → POP.
  - Otherwise → IDLE (note pending).
- Judgement commit, in CHECK:
  - PERFECT/GOOD: acc_score += PTS, acc_combo += 1, sev = max(sev, 1).
  - BAD: acc_score += BAD_PTS, sev = max(sev, 2).
  - MISS: sev = 3.
  - acc_score saturates at 8191; acc_combo saturates at 15.
- POP: note_pop=1 for exactly one cycle; → IDLE. The FIFO head is re-sampled no earlier than the next CHECK (≥2 cycles later).
- LATCH: score<=acc_score, combo<=acc_combo, precise<=sev; clear acc_*, sev, pend, frame_pend; → IDLE.
  - Outputs update 2–4 clk after the new_frame edge and are otherwise constant.
  - The drawer sampling at its own new_frame edge therefore reads the previous frame's totals.
- A new_frame edge during CHECK/POP is held in frame_pend and serviced after the return to IDLE; it is never lost.
- A second new_frame edge before LATCH merges with the first (single latch).
- Combo semantics with the drawer: a frame with any bad/miss has precise[1]=1, so the drawer zeroes the running combo and ignores the combo delta.
- active=0: FSM only services LATCH (publishing zeros); note_pop stays 0; pend is cleared every cycle.
- Simultaneous key edge and CHECK of the same lane in one cycle: the edge is registered into pend and takes effect at the next CHECK.

Test Plan:
- Reset release with idle inputs → score=0, combo=0, precise=0, note_pop never asserted over 3 frames.
- Note lane 2 at t=1000; key2 pressed at un_time=1030, frame edge after → one note_pop; next outputs score=300, combo=1, precise=1.
- Note lane 0 at t=500; no press; un_time sweeps to 621 → pop at un_time=621; frame totals score=0, combo=0, precise=3.
- Two notes (lane1 t=2000, lane3 t=2005); presses at 2060 (lane1) and 2110 (lane3) in one frame → score=150, combo=1, precise=2.
- Press lane 0 at un_time=100, note lane 0 at t=400 → no pop, no score; pend cleared; later press at 395 → PERFECT.
- new_frame edge arriving in the CHECK cycle of a perfect hit → hit lands in the closing frame (score=300), no edge lost; reset asserted during POP → note_pop drops immediately, outputs 0.
